mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MISALIGN_EN, default 1, meaning: 1 traps misaligned accesses; 0 ignores the low address bits and forces alignment.
REQ-002 Clk  input  1  single clock; all state on rising edge.
REQ-003 Clrn  input  1  reset, asynchronous, active-low.
REQ-004 Req  input  1  EX/MEM has a valid load/store this cycle.
REQ-005 Wr  input  1  1=store, 0=load.
REQ-006 Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Sign  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 Flush  input  1  abort the pending access.
REQ-009 Addr  input  32  byte address.
REQ-010 Wdata  input  32  store data, right-justified.
REQ-011 Rdata  output  32  extended load result.
REQ-012 Stall  output  1  pipeline SHALL hold EX/MEM inputs stable while high.
REQ-013 Done  output  1  one-cycle pulse when an access completes.
REQ-014 Misalign  output  1  one-cycle pulse on a misaligned or illegal access.
REQ-015 BadAddr  output  32  registered Addr of the last misaligned access.
REQ-016 mem_We  output  1  data-memory write enable; memory writes during the Clk-low phase.
REQ-017 mem_Addr  output  32  word address to data memory; bits [6:2] are used.
REQ-018 mem_Din  output  32  full word to write.
REQ-019 mem_Dout  input  32  combinational read word from data memory.

Function
REQ-020 The FSM SHALL have three states: IDLE, RMW_RD and RMW_WR.
REQ-021 Byte lanes SHALL be little-endian: lane k is bits [8k+7:8k] and is selected by Addr[1:0]; a halfword occupies lanes Addr[1]*2 and Addr[1]*2+1.
REQ-022 Misaligned means Size=01 with Addr[0]=1, or Size=10 with Addr[1:0]!=0; Size=11 is always illegal.
REQ-023 On a misaligned or illegal request in IDLE: Misalign=1 and Done=1 in the same cycle; mem_We=0; Rdata=0; BadAddr<=Addr at the clock edge; Stall=0.
REQ-024 For a load in IDLE: mem_Addr=Addr; Rdata=extracted and extended lane(s) of mem_Dout, combinational, zero latency; Done=1; Stall=0.
REQ-025 For a word store in IDLE: mem_We=1 and mem_Din=Wdata in the same cycle; Done=1; Stall=0.
REQ-026 For a sub-word store in IDLE: Stall=1, no write; latch Addr, Wdata and Size; next state RMW_RD.
REQ-027 In RMW_RD: mem_Addr=latched address; capture mem_Dout into the merge register; Stall=1; next state RMW_WR.
REQ-028 In RMW_WR: mem_We=1; mem_Din=merge word with only the target lane(s) replaced by the low byte or halfword of Wdata; Done=1; Stall=0; next state IDLE.
REQ-029 A sub-word store SHALL take 3 cycles, with Stall high in cycles 1-2.
REQ-030 In IDLE, Flush=1 SHALL suppress mem_We, Done and Misalign, and the FSM SHALL stay in IDLE.
REQ-031 In RMW_RD, Flush=1 SHALL return the FSM to IDLE with no write and no Done.
REQ-032 In RMW_WR, Flush SHALL be ignored; the write completes.
REQ-033 When Req=0 in IDLE: mem_We=0, Done=0, Stall=0, Rdata=0.
REQ-034 A new request SHALL only be accepted in IDLE; Req in other states is the held request.

Reset
REQ-035 While Clrn=0 the block SHALL force state=IDLE, mem_We=0, Stall=0, Done=0, Misalign=0, Rdata=0, BadAddr=0, and clear the latch and merge registers, asynchronously.
REQ-036 Reset during RMW_RD or RMW_WR SHALL abort the access with no partial write; mem_We SHALL drop immediately.

Verification
REQ-037 Word store then load: sw 0xDEADBEEF to 0x08, then lw 0x08 -> one write cycle, no Stall, Rdata=0xDEADBEEF.
REQ-038 Byte store RMW: word 0x11223344 at 0x10, sb 0xAA to 0x11 -> Stall high for 2 cycles, write on cycle 3, word=0x1122AA44; lb 0x11 -> 0xFFFFFFAA; lbu -> 0x000000AA.
REQ-039 Halfword: sh 0x8001 to 0x12 over 0x11223344 -> 0x80013344; lh 0x12 -> 0xFFFF8001.
REQ-040 Misalign: lw 0x0000_0006 -> Misalign=1, Done=1, no write, BadAddr=0x00000006; Size=11 -> Misalign=1.
REQ-041 Abort: sb issued, Flush in RMW_RD -> memory unchanged, FSM in IDLE; sb issued, Clrn pulsed low in RMW_WR -> mem_We=0 immediately, all outputs 0, memory unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with sub-word read-modify-write and misalignment trap
//
// Purpose: sits between the EX/MEM stage and a single-port word-wide data
// memory. Loads and word stores finish in one cycle. Byte and halfword
// stores read the target word, merge the new lane(s), then write the word
// back. This takes three cycles in total.
//
// Ports:
//   Clk, Clrn          clock and asynchronous active-low reset
//   Req, Wr, Size,     request from EX/MEM: valid, store/load, access size,
//   Sign, Addr, Wdata  load sign-extension, byte address, store data
//   Flush              abort the pending access
//   Rdata              extended load result (combinational)
//   Stall              hold EX/MEM inputs stable while high
//   Done, Misalign     one-cycle completion / trap pulses
//   BadAddr            address of the last trapped access
//   mem_We, mem_Addr,  data memory write enable, address and write word;
//   mem_Din, mem_Dout  read word comes back combinationally

module mem_access_unit #(
  parameter int MISALIGN_EN = 1
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Sign,
  input  logic        Flush,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        Stall,
  output logic        Done,
  output logic        Misalign,
  output logic [31:0] BadAddr,
  output logic        mem_We,
  output logic [31:0] mem_Addr,
  output logic [31:0] mem_Din,
  input  logic [31:0] mem_Dout
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [1:0]  lat_size;
  logic [31:0] merge_q;

  logic        illegal, misal_raw, bad;
  logic [31:0] eff_addr;
  logic        accept;

  // Pick the addressed lane(s) out of a word and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extract = {{24{sg & b[7]}}, b};
      2'b01:   extract = {{16{sg & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane(s) of w with the low byte/halfword of d.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                        input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: r[{lo, 3'b000} +: 8] = d[7:0];
      2'b01: if (lo[1]) r[31:16] = d; else r[15:0] = d;
      default: r = w;
    endcase
    merge = r;
  endfunction

  always_comb begin
    illegal   = (Size == 2'b11);
    misal_raw = ((Size == 2'b01) && Addr[0]) || ((Size == 2'b10) && (Addr[1:0] != 2'b00));
    bad       = illegal || ((MISALIGN_EN != 0) && misal_raw);
    // With trapping disabled, the low bits are dropped so the access is naturally aligned.
    eff_addr  = Addr;
    if (MISALIGN_EN == 0) begin
      if (Size == 2'b01) eff_addr = {Addr[31:1], 1'b0};
      if (Size == 2'b10) eff_addr = {Addr[31:2], 2'b00};
    end
    accept = (state_q == IDLE) && Req && !Flush;
  end

  always_comb begin
    state_d  = state_q;
    Rdata    = 32'h0;
    Stall    = 1'b0;
    Done     = 1'b0;
    Misalign = 1'b0;
    mem_We   = 1'b0;
    mem_Addr = eff_addr;
    mem_Din  = Wdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            Done     = 1'b1;
            Misalign = 1'b1;
          end else if (!Wr) begin
            Rdata = extract(mem_Dout, eff_addr[1:0], Size, Sign);
            Done  = 1'b1;
          end else if (Size == 2'b10) begin
            mem_We = 1'b1;
            Done   = 1'b1;
          end else begin
            Stall   = 1'b1;
            state_d = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        mem_Addr = lat_addr;
        if (Flush) begin
          state_d = IDLE;
        end else begin
          Stall   = 1'b1;
          state_d = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_Addr = lat_addr;
        mem_We   = 1'b1;
        mem_Din  = merge(merge_q, lat_wdata, lat_addr[1:0], lat_size);
        Done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the strobes immediately, not at the next edge,
    // so an interrupted read-modify-write never reaches memory.
    if (!Clrn) begin
      Rdata    = 32'h0;
      Stall    = 1'b0;
      Done     = 1'b0;
      Misalign = 1'b0;
      mem_We   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= IDLE;
      BadAddr   <= 32'h0;
      lat_addr  <= 32'h0;
      lat_wdata <= 16'h0;
      lat_size  <= 2'b00;
      merge_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept && bad) BadAddr <= Addr;
      if (accept && !bad && Wr && (Size != 2'b10)) begin
        lat_addr  <= eff_addr;
        lat_wdata <= Wdata[15:0];
        lat_size  <= Size;
      end
      if ((state_q == RMW_RD) && !Flush) merge_q <= mem_Dout;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit

module tb_mem_access_unit;

  logic        Clk, Clrn, Req, Wr, Sign, Flush;
  logic [1:0]  Size;
  logic [31:0] Addr, Wdata, Rdata, BadAddr, mem_Addr, mem_Din, mem_Dout;
  logic        Stall, Done, Misalign, mem_We;

  logic [31:0] mem [32];
  int n_pass = 0;
  int n_total = 0;

  mem_access_unit #(.MISALIGN_EN(1)) dut (
    .Clk(Clk), .Clrn(Clrn), .Req(Req), .Wr(Wr), .Size(Size), .Sign(Sign),
    .Flush(Flush), .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata), .Stall(Stall),
    .Done(Done), .Misalign(Misalign), .BadAddr(BadAddr), .mem_We(mem_We),
    .mem_Addr(mem_Addr), .mem_Din(mem_Din), .mem_Dout(mem_Dout)
  );

  always #5 Clk = ~Clk;

  // Data memory: combinational read, write during the clock-low phase.
  assign mem_Dout = mem[mem_Addr[6:2]];
  always @(negedge Clk) if (mem_We) mem[mem_Addr[6:2]] <= mem_Din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic op(input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] d);
    Req = 1'b1; Wr = wr; Size = sz; Sign = sg; Addr = a; Wdata = d; Flush = 1'b0;
  endtask

  task automatic idle();
    Req = 1'b0; Wr = 1'b0; Size = 2'b00; Sign = 1'b0; Addr = 32'h0; Wdata = 32'h0; Flush = 1'b0;
  endtask

  initial begin
    Clk = 1'b0; Clrn = 1'b1;
    idle();
    #1 Clrn = 1'b0;
    #2;
    chk("rst_rdata",    Rdata,    32'h0);
    chk("rst_stall",    Stall,    32'h0);
    chk("rst_done",     Done,     32'h0);
    chk("rst_misalign", Misalign, 32'h0);
    chk("rst_badaddr",  BadAddr,  32'h0);
    chk("rst_we",       mem_We,   32'h0);
    tick(); tick();
    Clrn = 1'b1;

    // preload 0x10 with a word store
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    #2;
    chk("sw10_we", mem_We, 32'h1);
    tick();

    // sw 0xDEADBEEF to 0x08, then lw 0x08
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    #2;
    chk("sw_we",    mem_We,  32'h1);
    chk("sw_din",   mem_Din, 32'hDEADBEEF);
    chk("sw_stall", Stall,   32'h0);
    chk("sw_done",  Done,    32'h1);
    tick();
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    #2;
    chk("lw_rdata", Rdata,  32'hDEADBEEF);
    chk("lw_done",  Done,   32'h1);
    chk("lw_we",    mem_We, 32'h0);
    chk("mem2",     mem[2], 32'hDEADBEEF);
    tick();

    // sb 0xAA to 0x11 over 0x11223344 (upper data bits must be ignored)
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA);
    #2;
    chk("sb_c1_stall", Stall,  32'h1);
    chk("sb_c1_we",    mem_We, 32'h0);
    chk("sb_c1_done",  Done,   32'h0);
    tick();
    #2;
    chk("sb_c2_stall", Stall,    32'h1);
    chk("sb_c2_we",    mem_We,   32'h0);
    chk("sb_c2_addr",  mem_Addr, 32'h11);
    tick();
    #2;
    chk("sb_c3_we",    mem_We,  32'h1);
    chk("sb_c3_din",   mem_Din, 32'h1122AA44);
    chk("sb_c3_done",  Done,    32'h1);
    chk("sb_c3_stall", Stall,   32'h0);
    tick();
    chk("sb_mem", mem[4], 32'h1122AA44);
    op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    #2;
    chk("lb",  Rdata, 32'hFFFFFFAA);
    Sign = 1'b0;
    #1;
    chk("lbu", Rdata, 32'h000000AA);
    tick();

    // restore 0x11223344, then sh 0x8001 to 0x12
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    tick();
    op(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
    tick(); tick();
    #2;
    chk("sh_din", mem_Din, 32'h80013344);
    tick();
    chk("sh_mem", mem[4], 32'h80013344);
    op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    #2;
    chk("lh", Rdata, 32'hFFFF8001);
    Sign = 1'b0;
    #1;
    chk("lhu", Rdata, 32'h00008001);
    tick();

    // misaligned lw 0x06
    op(1'b0, 2'b10, 1'b1, 32'h06, 32'h0);
    #2;
    chk("mis_flag",  Misalign, 32'h1);
    chk("mis_done",  Done,     32'h1);
    chk("mis_we",    mem_We,   32'h0);
    chk("mis_rdata", Rdata,    32'h0);
    chk("mis_stall", Stall,    32'h0);
    tick();
    idle();
    #2;
    chk("mis_badaddr", BadAddr,  32'h6);
    chk("mis_pulse",   Misalign, 32'h0);
    chk("idle_done",   Done,     32'h0);
    chk("idle_rdata",  Rdata,    32'h0);
    tick();
    // misaligned halfword store: no write, no stall
    op(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF);
    #2;
    chk("mis_sh_we",    mem_We,   32'h0);
    chk("mis_sh_stall", Stall,    32'h0);
    chk("mis_sh_flag",  Misalign, 32'h1);
    tick();
    // Size=11 is illegal even when aligned
    op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    #2;
    chk("ill_flag", Misalign, 32'h1);
    tick();
    chk("ill_badaddr", BadAddr, 32'h20);

    // Flush in IDLE suppresses a word store
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'h0BADF00D);
    Flush = 1'b1;
    #2;
    chk("fl_idle_we",   mem_We, 32'h0);
    chk("fl_idle_done", Done,   32'h0);
    tick();
    chk("fl_idle_mem", mem[2], 32'hDEADBEEF);

    // sb then Flush in RMW_RD
    op(1'b1, 2'b00, 1'b0, 32'h10, 32'h55);
    tick();
    Flush = 1'b1;
    #2;
    chk("fl_rd_we", mem_We, 32'h0);
    tick();
    idle();
    #2;
    chk("fl_after_we",    mem_We, 32'h0);
    chk("fl_after_done",  Done,   32'h0);
    chk("fl_after_stall", Stall,  32'h0);
    tick();
    chk("fl_mem", mem[4], 32'h80013344);
    // FSM back in IDLE: a load completes immediately
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    #2;
    chk("fl_lw_rdata", Rdata, 32'h80013344);
    chk("fl_lw_stall", Stall, 32'h0);
    tick();

    // sb then reset pulse in RMW_WR
    op(1'b1, 2'b00, 1'b0, 32'h10, 32'h55);
    tick(); tick();
    #2;
    chk("rw_we_pre",  mem_We,  32'h1);
    chk("rw_din_pre", mem_Din, 32'h80013355);
    Clrn = 1'b0;
    #1;
    chk("rw_we",    mem_We,   32'h0);
    chk("rw_done",  Done,     32'h0);
    chk("rw_stall", Stall,    32'h0);
    chk("rw_rdata", Rdata,    32'h0);
    chk("rw_mis",   Misalign, 32'h0);
    chk("rw_bad",   BadAddr,  32'h0);
    tick();
    Clrn = 1'b1;
    idle();
    tick();
    chk("rw_mem", mem[4], 32'h80013344);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
